// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide unsigned adder sequenced through one 4-bit add-with-carry slice
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START_VALID,
    output logic                 START_READY,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 DONE_VALID,
    input  logic                 DONE_READY,
    output logic [4*NIBBLES:0]   X
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    x_q, x_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [4:0]    sum;
    logic          last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Only the latched operands feed the slice, so A/B may change after the start transfer.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
        sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};
        last = (idx_q == IW'(NIBBLES - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (START_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    x_d     = '0;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (idx_q == IW'(k)) begin
                        x_d[4*k +: 4] = sum[3:0];
                    end
                end
                carry_d = sum[4];
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    x_d[W]  = sum[4];
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (DONE_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign START_READY = (state_q == S_IDLE);
    assign DONE_VALID  = (state_q == S_DONE);
    assign X           = x_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst;
    logic        sv, sr, dv, dr;
    logic [15:0] ai, bi;
    logic [16:0] x;
    logic        sv1, sr1, dv1, dr1;
    logic [3:0]  a1, b1;
    logic [4:0]  x1;
    int          total;
    int          bad;

    nibble_serial_adder #(.NIBBLES(4)) u4 (
        .CLK(clk), .RST(rst),
        .START_VALID(sv), .START_READY(sr), .A(ai), .B(bi),
        .DONE_VALID(dv), .DONE_READY(dr), .X(x)
    );

    nibble_serial_adder #(.NIBBLES(1)) u1 (
        .CLK(clk), .RST(rst),
        .START_VALID(sv1), .START_READY(sr1), .A(a1), .B(b1),
        .DONE_VALID(dv1), .DONE_READY(dr1), .X(x1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit scramble);
        logic [16:0] exp;
        int cnt;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        sv = 1'b1; ai = a; bi = b; dr = (hold == 0);
        total++;
        if (sr !== 1'b1) begin bad++; $display("FAIL start_ready got=%b want=1", sr); end
        @(negedge clk);
        sv = 1'b0;
        if (scramble) begin ai = 16'hAAAA; bi = 16'hAAAA; end
        else begin ai = 16'($urandom); bi = 16'($urandom); end
        cnt = 0;
        while (dv !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        total++;
        if (cnt != 4) begin bad++; $display("FAIL latency got=%0d want=4", cnt); end
        total++;
        if (x !== exp) begin bad++; $display("FAIL sum a=%h b=%h got=%h want=%h", a, b, x, exp); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (dv !== 1'b1 || sr !== 1'b0 || x !== exp) begin
                bad++; $display("FAIL hold dv=%b sr=%b x=%h want dv=1 sr=0 x=%h", dv, sr, x, exp);
            end
            if (i == hold - 1) dr = 1'b1;
        end
        @(negedge clk);
        total++;
        if (dv !== 1'b0 || sr !== 1'b1 || x !== exp) begin
            bad++; $display("FAIL release dv=%b sr=%b x=%h want dv=0 sr=1 x=%h", dv, sr, x, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (sr !== 1'b1 || dv !== 1'b0 || x !== 17'h0) begin
            bad++; $display("FAIL reset4 sr=%b dv=%b x=%h want 1 0 0", sr, dv, x);
        end
        total++;
        if (sr1 !== 1'b1 || dv1 !== 1'b0 || x1 !== 5'h0) begin
            bad++; $display("FAIL reset1 sr=%b dv=%b x=%h want 1 0 0", sr1, dv1, x1);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1, 1'b0);
    endtask

    task automatic test_operand_change();
        run_op(16'h0F0F, 16'h00F1, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        int cnt;
        @(negedge clk);
        sv = 1'b1; ai = 16'h1234; bi = 16'h4321; dr = 1'b0;
        @(negedge clk);
        sv = 1'b0;
        cnt = 0;
        while (dv !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        for (int i = 0; i < 10; i++) begin
            sv = 1'b1; ai = 16'h1111; bi = 16'h2222;
            total++;
            if (dv !== 1'b1 || sr !== 1'b0 || x !== 17'h05555) begin
                bad++; $display("FAIL backpressure dv=%b sr=%b x=%h want 1 0 05555", dv, sr, x);
            end
            @(negedge clk);
        end
        dr = 1'b1;
        @(negedge clk);
        total++;
        if (dv !== 1'b0 || sr !== 1'b1 || x !== 17'h05555) begin
            bad++; $display("FAIL bp_release dv=%b sr=%b x=%h want 0 1 05555", dv, sr, x);
        end
        @(negedge clk);
        sv = 1'b0;
        cnt = 0;
        while (dv !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        total++;
        if (cnt != 4 || x !== 17'h03333) begin
            bad++; $display("FAIL bp_next cnt=%0d x=%h want 4 03333", cnt, x);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        sv = 1'b1; ai = 16'hFFFF; bi = 16'h0001; dr = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (x !== 17'h0 || dv !== 1'b0 || sr !== 1'b1) begin
            bad++; $display("FAIL mid_reset x=%h dv=%b sr=%b want 0 0 1", x, dv, sr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (dv !== 1'b0 || sr !== 1'b1) begin
                bad++; $display("FAIL post_reset dv=%b sr=%b want 0 1", dv, sr);
            end
        end
        run_op(16'h0001, 16'h0001, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_dv;
        @(negedge clk);
        sv1 = 1'b1; a1 = 4'hF; b1 = 4'hF; dr1 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            exp_dv = ((i % 3) == 2);
            total++;
            if (dv1 !== exp_dv || sr1 !== ((i % 3) == 0)) begin
                bad++; $display("FAIL b2b cycle=%0d dv=%b sr=%b want dv=%b", i, dv1, sr1, exp_dv);
            end
            if (exp_dv) begin
                total++;
                if (x1 !== 5'h1E) begin bad++; $display("FAIL b2b_sum got=%h want=1e", x1); end
            end
        end
        sv1 = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        sv = 1'b0; dr = 1'b1; ai = '0; bi = '0;
        sv1 = 1'b0; dr1 = 1'b1; a1 = '0; b1 = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequencer that adds two wide unsigned operands through a single 4-bit add-with-carry slice, processing one nibble per clock from least to most significant. Each operation is accepted on a valid/ready start handshake and returned on a valid/ready done handshake. Wide additions therefore cost one 4-bit adder plus registers instead of a full-width ripple chain. It sits between a requester (CPU register block or testbench driver) and the shared nibble adder datapath.

## Interface
Parameters:
- NIBBLES, default 4: operand width in nibbles (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START_VALID  input  1  requester presents operands A/B.
- START_READY  output  1  block can accept operands; high only in IDLE.
- A  input  W  operand A, sampled only on start transfer.
- B  input  W  operand B, sampled only on start transfer.
- DONE_VALID  output  1  X holds a completed sum.
- DONE_READY  input  1  consumer accepts X.
- X  output  W+1  sum; X[W] is final carry-out.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: state=IDLE, X=0, carry=0, nibble index=0, DONE_VALID=0; START_READY=1 (combinational from IDLE). No transfer completes while RST is high.
- Start transfer = START_VALID && START_READY at a rising edge: latch A, B into operand registers, clear carry, index=0, clear X, go to RUN.
- RUN, each cycle at index i: {c, s} = A[4i+3:4i] + B[4i+3:4i] + carry (5-bit result). At the edge: X[4i+3:4i] <= s, carry <= c, index <= i+1.
- At the edge where i = NIBBLES-1, also write X[W] <= c and go to DONE.
- DONE: DONE_VALID=1; X, operands and state held until DONE_READY=1, then go to IDLE at that edge.
- START_VALID and A/B are ignored outside IDLE; the operand registers alone feed the adder during RUN, so operands may change after the start transfer.
- Unsigned arithmetic only; no overflow flag. Overflow is carried in X[W].
- Reset asserted mid-RUN or in DONE: the operation is abandoned immediately, outputs return to reset values, and no DONE transfer occurs for that operation.

## Timing
- Start transfer at edge t0. RUN occupies cycles t0+1 .. t0+NIBBLES. DONE_VALID rises after edge t0+NIBBLES.
- Latency from start edge to first DONE_VALID cycle: NIBBLES edges.
- Done transfer at edge t1 leads to IDLE. START_READY=1 from the cycle after t1. No same-cycle restart.
- Maximum throughput with DONE_READY tied high: one operation per NIBBLES+2 cycles.
- X bits change only at RUN edges. X is stable and valid for every cycle DONE_VALID=1. X retains its last sum in IDLE until the next start transfer clears it.
- START_READY and DONE_VALID are decoded from state only, with no combinational path from inputs.

## Test plan
- NIBBLES=4, A=0x1234, B=0x4321, DONE_READY=1 -> DONE_VALID 4 cycles after the start edge, X=0x05555, one-cycle pulse, START_READY high the following cycle.
- NIBBLES=4, A=0xFFFF, B=0x0001 -> full carry ripple across all nibbles, X=0x10000. Then A=0xFFFF, B=0xFFFF -> X=0x1FFFE.
- Backpressure: DONE_READY=0 for 10 cycles after DONE_VALID -> X=0x05555 and DONE_VALID held constant. START_VALID=1 with new operands is ignored (START_READY=0). Release DONE_READY -> IDLE, then the new operands are accepted.
- Operand change: A/B driven to 0xAAAA one cycle after the start of 0x0F0F+0x00F1 -> X=0x01000, unaffected by the change.
- Reset mid-RUN: assert RST asynchronously after 2 RUN cycles of 0xFFFF+0x0001 -> X=0, DONE_VALID=0 immediately, START_READY=1 after release. The next operation 0x0001+0x0001 -> X=0x00002.
- NIBBLES=1, A=0xF, B=0xF, START_VALID held high continuously, DONE_READY=1 -> X=0x1E after 1 cycle, with back-to-back operations every 3 cycles.
